// File: rtl/sram_bank_controller_pkg.sv
// Shared constants for the SRAM bank controller.
// Read latency follows SRAM_BANK_OUT_REG_EN: 3 cycles when defined, 2 otherwise.
package sram_bank_controller_pkg;

    localparam int DEF_XLEN           = 32;
    localparam int DEF_LANE_W         = 16;
    localparam int DEF_BANK_ADDR_BITS = 13;
    localparam int DEF_NUM_BANKS      = 2;
    localparam int DEF_MEM_ADDR_BITS  = 16;

    // Width of the rd_count / wr_count access counters
    localparam int CNT_W = 16;

`ifdef SRAM_BANK_OUT_REG_EN
    localparam int READ_LATENCY = 3;
`else
    localparam int READ_LATENCY = 2;
`endif

endpackage

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM lane with byte write enables.
// Registered read returns the word stored before a same-cycle write.
module single_port_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read-before-write access with per-byte write enables; contents never reset
    always_ff @(posedge clk) begin
        rdata <= mem[addr];
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/sram_bank_controller.sv
// Banked SRAM controller: address decode, lane write enables, fixed-latency
// read pipeline with per-bank output mux, and saturating access counters.
// Optional feature macro: SRAM_BANK_OUT_REG_EN adds one output register stage
// (read latency 3 instead of 2); write path and counters are unchanged.
module sram_bank_controller
    import sram_bank_controller_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int LANE_W         = DEF_LANE_W,
    parameter int BANK_ADDR_BITS = DEF_BANK_ADDR_BITS,
    parameter int NUM_BANKS      = DEF_NUM_BANKS,
    parameter int MEM_ADDR_BITS  = DEF_MEM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic [MEM_ADDR_BITS-1:0] mem_addr,
    input  logic                     mem_read_en,
    input  logic [XLEN/8-1:0]        mem_write_en,
    input  logic [XLEN-1:0]          mem_write_data,
    output logic [XLEN-1:0]          mem_read_data,
    output logic                     mem_read_ack,
    output logic                     mem_write_ack,
    output logic                     mem_err,
    output logic [CNT_W-1:0]         rd_count,
    output logic [CNT_W-1:0]         wr_count
);

    localparam int LANES      = XLEN / LANE_W;
    localparam int LANE_BYTES = LANE_W / 8;
    localparam int BANK_BITS  = $clog2(NUM_BANKS);
    localparam int BANK_SEL_W = (BANK_BITS > 0) ? BANK_BITS : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic                     ext;
    logic                     in_range;
    logic                     access_ok;
    logic                     wr_allowed;
    logic                     wr_any;
    logic                     wr_err;
    logic [BANK_SEL_W-1:0]    bank_idx;
    logic [MEM_ADDR_BITS-2:0] low_addr;
    logic [NUM_BANKS*XLEN-1:0] ram_rdata;
    logic [XLEN-1:0]          rd_mux_p1;

    logic                     vld_p1, err_p1;
    logic [BANK_SEL_W-1:0]    bank_p1;
    logic                     vld_p2, err_p2;
    logic [XLEN-1:0]          rd_data_p2;

    // Decode: MSB selects the external region, bits above the bank index must be zero
    assign ext        = mem_addr[MEM_ADDR_BITS-1];
    assign low_addr   = mem_addr[MEM_ADDR_BITS-2:0];
    assign in_range   = ((low_addr >> (BANK_ADDR_BITS + BANK_BITS)) == '0);
    assign access_ok  = ~ext & in_range;
    assign wr_allowed = reset_n & ~sync_reset;
    assign wr_any     = |mem_write_en;

    assign mem_write_ack = wr_any & access_ok & wr_allowed;
    assign wr_err        = wr_any & ~access_ok & wr_allowed;

    generate
        if (BANK_BITS > 0) begin : g_bank_idx
            assign bank_idx = mem_addr[BANK_ADDR_BITS +: BANK_SEL_W];
        end else begin : g_single_bank
            assign bank_idx = '0;
        end
    endgenerate

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic bank_hit;
            assign bank_hit = (int'(bank_idx) == b);
            for (genvar l = 0; l < LANES; l++) begin : g_lane
                logic [LANE_BYTES-1:0] lane_we;
                assign lane_we = mem_write_en[l*LANE_BYTES +: LANE_BYTES]
                               & {LANE_BYTES{bank_hit & access_ok & wr_allowed}};
                single_port_ram #(
                    .ADDR_W (BANK_ADDR_BITS),
                    .DATA_W (LANE_W)
                ) u_ram (
                    .clk   (clk),
                    .addr  (mem_addr[BANK_ADDR_BITS-1:0]),
                    .we    (lane_we),
                    .wdata (mem_write_data[l*LANE_W +: LANE_W]),
                    .rdata (ram_rdata[b*XLEN + l*LANE_W +: LANE_W])
                );
            end
        end
    endgenerate

    // ---- stage p1: RAM output valid, qualifiers travel with it ----

    // Read valid and error flag for the access captured this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (sync_reset) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= mem_read_en;
            err_p1 <= ~access_ok;
        end
    end

    // Bank index follows the read; qualified by vld_p1 so it needs no reset
    always_ff @(posedge clk) begin
        bank_p1 <= bank_idx;
    end

    // Select the word from the bank addressed when the read was issued
    always_comb begin
        rd_mux_p1 = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(bank_p1) == b) begin
                rd_mux_p1 = ram_rdata[b*XLEN +: XLEN];
            end
        end
    end

    // ---- stage p2: registered read result, held between acks ----

    // Capture muxed data (zeroed on error) only when a read completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2     <= 1'b0;
            err_p2     <= 1'b0;
            rd_data_p2 <= '0;
        end else if (sync_reset) begin
            vld_p2     <= 1'b0;
            err_p2     <= 1'b0;
            rd_data_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            err_p2 <= vld_p1 & err_p1;
            if (vld_p1) begin
                rd_data_p2 <= err_p1 ? '0 : rd_mux_p1;
            end
        end
    end

`ifdef SRAM_BANK_OUT_REG_EN
    logic            vld_p3, err_p3;
    logic [XLEN-1:0] rd_data_p3;

    // ---- stage p3: extra output register, everything delayed equally ----

    // Delay ack, error and data by one more cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p3     <= 1'b0;
            err_p3     <= 1'b0;
            rd_data_p3 <= '0;
        end else if (sync_reset) begin
            vld_p3     <= 1'b0;
            err_p3     <= 1'b0;
            rd_data_p3 <= '0;
        end else begin
            vld_p3 <= vld_p2;
            err_p3 <= err_p2;
            if (vld_p2) begin
                rd_data_p3 <= rd_data_p2;
            end
        end
    end

    assign mem_read_ack  = vld_p3;
    assign mem_read_data = rd_data_p3;
    assign mem_err       = err_p3 | wr_err;
`else
    assign mem_read_ack  = vld_p2;
    assign mem_read_data = rd_data_p2;
    assign mem_err       = err_p2 | wr_err;
`endif

    // Saturating access counters driven by the acks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (sync_reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (mem_read_ack)  rd_count <= sat_inc(rd_count);
            if (mem_write_ack) wr_count <= sat_inc(wr_count);
        end
    end

endmodule

// File: doc/sram_bank_controller.md
SRAM_BANK_CONTROLLER -- requirements
Module: sram_bank_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits; multiple of LANE_W.
REQ-002 SHALL have parameter LANE_W, default 16, width of one RAM lane in bits; multiple of 8.
REQ-003 SHALL have parameter BANK_ADDR_BITS, default 13, word-address bits per bank.
REQ-004 SHALL have parameter NUM_BANKS, default 2, number of depth banks; power of 2, minimum 1.
REQ-005 SHALL have parameter MEM_ADDR_BITS, default 16, word-address width; must exceed BANK_ADDR_BITS + log2(NUM_BANKS).
REQ-006 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port sync_reset, input, 1, synchronous reset, same effect as reset_n.
REQ-009 SHALL have port mem_addr, input, MEM_ADDR_BITS, word address.
REQ-010 SHALL have port mem_read_en, input, 1, single-cycle read strobe.
REQ-011 SHALL have port mem_write_en, input, XLEN/8, byte-lane write strobes.
REQ-012 SHALL have port mem_write_data, input, XLEN, write data.
REQ-013 SHALL have port mem_read_data, output, XLEN, read data, valid with mem_read_ack.
REQ-014 SHALL have port mem_read_ack, output, 1, read completion pulse.
REQ-015 SHALL have port mem_write_ack, output, 1, write completion pulse, combinational.
REQ-016 SHALL have port mem_err, output, 1, error pulse, coincident with the ack of a failed access.
REQ-017 SHALL have ports rd_count and wr_count, output, 16 each, saturating access counters.

Function
REQ-018 Address decode: MSB = 1 selects external region; bank index = mem_addr[BANK_ADDR_BITS +: log2(NUM_BANKS)]; bits between bank index and MSB must be zero, else out-of-range.
REQ-019 Each bank SHALL hold XLEN/LANE_W lanes; a lane's write enable = its byte strobes AND bank selected AND in range.
REQ-020 Read latency SHALL be fixed at 2 cycles: strobe at cycle N -> data registered at N+1 -> mem_read_ack and mem_read_data at N+2.
REQ-021 Bank index SHALL be pipelined alongside the read so the output mux selects the bank addressed at cycle N.
REQ-022 Back-to-back reads every cycle SHALL produce one ack per cycle, in order, without loss.
REQ-023 mem_write_ack SHALL equal (|mem_write_en) AND in-range AND NOT external, same cycle.
REQ-024 External or out-of-range read SHALL still produce mem_read_ack at N+2, with mem_err = 1 and mem_read_data = 0.
REQ-025 External or out-of-range write SHALL write nothing, give mem_write_ack = 0, and give mem_err = 1 in the same cycle.
REQ-026 Simultaneous read and write to the same address SHALL write the new data; the returned read data SHALL be the old word (read-before-write).
REQ-027 rd_count SHALL increment on each mem_read_ack.
REQ-028 wr_count SHALL increment on each mem_write_ack.
REQ-029 rd_count and wr_count SHALL saturate at 0xFFFF.
REQ-030 mem_read_data SHALL hold its value between acks.

Reset
REQ-031 Under reset_n low or sync_reset high: mem_read_ack = 0, mem_err = 0, mem_read_data = 0, counters = 0.
REQ-032 Under reset, the read pipeline SHALL be flushed.
REQ-033 A read in flight when reset asserts SHALL never be acknowledged.
REQ-034 RAM contents SHALL be unaffected by reset.
REQ-035 Writes SHALL be blocked while sync_reset is high.

Configuration
REQ-036 Macro SRAM_BANK_OUT_REG_EN defined: one extra output register stage; read latency 3 cycles; mem_err, data and bank-select pipelines extended equally.
REQ-037 SRAM_BANK_OUT_REG_EN undefined: read latency 2 cycles.
REQ-038 Write path and counters SHALL be identical with and without SRAM_BANK_OUT_REG_EN.

Structure
REQ-039 Shared package SHALL hold default parameter constants, the read-latency constant (derived from the macro), and the counter width.
REQ-040 The existing single_port_ram sub-module SHALL be instantiated NUM_BANKS x (XLEN/LANE_W) times via generate.
REQ-041 No other sub-module SHALL be used.

Verification
REQ-042 Write 0xDEADBEEF at 0x0010 (strobes 0xF), then read 0x0010: mem_write_ack pulse; read ack at N+2 with 0xDEADBEEF; wr_count = 1, rd_count = 1.
REQ-043 Partial write 0x0000AA00 with strobe 0x2 over 0x11223344: read returns 0x1122AA44.
REQ-044 Write 0x1 to bank 0 word 5 and 0x2 to bank 1 word 5; four back-to-back reads alternating banks: acks on 4 consecutive cycles with data 1, 2, 1, 2.
REQ-045 Read at address 0x8000: ack at N+2 with mem_err = 1 and data 0. Write at 0x8000: mem_write_ack = 0, mem_err = 1, RAM unchanged.
REQ-046 Issue a read, then pulse sync_reset at N+1: no ack, counters = 0. Repeat with SRAM_BANK_OUT_REG_EN defined and confirm 3-cycle latency.
REQ-047 Preload wr_count to 0xFFFE by issuing writes; two more writes: wr_count stays 0xFFFF.
